// File: rtl/attack_map_collect_pkg.sv
// Shared chess encodings plus the state and back-rank constants used by the
// attack-map collector.
package attack_map_collect_pkg;

  localparam int CHESS_PIECE_WIDTH = 4;

  // Piece codes (one square = CHESS_PIECE_WIDTH bits)
  localparam logic [3:0] EMPTY_POSN   = 4'd0;
  localparam logic [3:0] WHITE_PAWN   = 4'd1;
  localparam logic [3:0] WHITE_KNIGHT = 4'd2;
  localparam logic [3:0] WHITE_BISHOP = 4'd3;
  localparam logic [3:0] WHITE_ROOK   = 4'd4;
  localparam logic [3:0] WHITE_QUEEN  = 4'd5;
  localparam logic [3:0] WHITE_KING   = 4'd6;
  localparam logic [3:0] BLACK_PAWN   = 4'd9;
  localparam logic [3:0] BLACK_KNIGHT = 4'd10;
  localparam logic [3:0] BLACK_BISHOP = 4'd11;
  localparam logic [3:0] BLACK_ROOK   = 4'd12;
  localparam logic [3:0] BLACK_QUEEN  = 4'd13;
  localparam logic [3:0] BLACK_KING   = 4'd14;

  // Attacking side selector
  localparam int WHITE_ATTACK = 0;
  localparam int BLACK_ATTACK = 1;

  // Home rows of each side
  localparam logic [2:0] BACK_RANK_WHITE = 3'd0;
  localparam logic [2:0] BACK_RANK_BLACK = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_SCAN    = 2'd2,
    ST_DONE    = 2'd3
  } state_e;

  // True when the three consecutive squares starting at (rank, col) are all
  // unattacked. col must be <= 5 so the span stays inside the rank.
  function automatic logic span_clear(input logic [63:0] map,
                                      input logic [2:0]  rank,
                                      input logic [2:0]  col);
    logic [5:0] base;
    base = {rank, col};
    return ~|map[base +: 3];
  endfunction

endpackage

// File: rtl/attack_map_collect_row_king_find.sv
// Combinational search of one board row for a king code; reports whether it
// is present and the lowest column holding it.
module row_king_find
  import attack_map_collect_pkg::*;
#(
  parameter int PIECE_WIDTH = CHESS_PIECE_WIDTH,
  parameter int SIDE_WIDTH  = 8*PIECE_WIDTH
) (
  input  logic [SIDE_WIDTH-1:0]  row_i,
  input  logic [PIECE_WIDTH-1:0] king_code_i,
  output logic                   hit_o,
  output logic [2:0]             col_o
);

  // Scan high to low so the last match assigned is the lowest column
  always_comb begin
    hit_o = 1'b0;
    col_o = 3'd0;
    for (int c = 7; c >= 0; c--) begin
      if (row_i[c*PIECE_WIDTH +: PIECE_WIDTH] == king_code_i) begin
        hit_o = 1'b1;
        col_o = 3'(c);
      end
    end
  end

endmodule

// File: rtl/attack_map_collect.sv
// Collects the per-square attack bank pulses into one attack map, then walks
// the latched board row by row to find the defending king, and publishes
// check / castling-path safety with a valid/ready handshake.
module attack_map_collect
  import attack_map_collect_pkg::*;
#(
  parameter int PIECE_WIDTH = CHESS_PIECE_WIDTH,
  parameter int SIDE_WIDTH  = 8*PIECE_WIDTH,
  parameter int BOARD_WIDTH = 64*PIECE_WIDTH,
  parameter int ATTACKER    = WHITE_ATTACK
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [BOARD_WIDTH-1:0] board,
  input  logic                   board_valid,
  input  logic [63:0]            attacked,
  input  logic [63:0]            attacked_valid,
  output logic                   busy,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [63:0]            attack_map,
  output logic                   king_found,
  output logic [5:0]             king_sq,
  output logic                   in_check,
  output logic                   castle_short_safe,
  output logic                   castle_long_safe
);

  localparam logic [PIECE_WIDTH-1:0] KING_CODE =
    (ATTACKER == WHITE_ATTACK) ? PIECE_WIDTH'(BLACK_KING) : PIECE_WIDTH'(WHITE_KING);
  localparam logic [2:0] BACK_RANK =
    (ATTACKER == WHITE_ATTACK) ? BACK_RANK_BLACK : BACK_RANK_WHITE;

  state_e                 state_q, state_d;
  logic [BOARD_WIDTH-1:0] board_q, board_d;
  logic [63:0]            mask_q, mask_d;
  logic [2:0]             row_q, row_d;
  logic [63:0]            map_q, map_d;
  logic                   kf_q, kf_d;
  logic [5:0]             ksq_q, ksq_d;
  logic                   chk_q, chk_d;
  logic                   cs_q, cs_d;
  logic                   cl_q, cl_d;
  logic                   ov_q, ov_d;

  logic [SIDE_WIDTH-1:0]  row_bits;
  logic                   row_hit;
  logic [2:0]             row_col;

  assign row_bits = board_q[int'(row_q)*SIDE_WIDTH +: SIDE_WIDTH];

  row_king_find #(
    .PIECE_WIDTH (PIECE_WIDTH),
    .SIDE_WIDTH  (SIDE_WIDTH)
  ) u_row_find (
    .row_i       (row_bits),
    .king_code_i (KING_CODE),
    .hit_o       (row_hit),
    .col_o       (row_col)
  );

  // Next-state and result-register updates for the collect/scan sequence
  always_comb begin
    state_d = state_q;
    board_d = board_q;
    mask_d  = mask_q;
    row_d   = row_q;
    map_d   = map_q;
    kf_d    = kf_q;
    ksq_d   = ksq_q;
    chk_d   = chk_q;
    cs_d    = cs_q;
    cl_d    = cl_q;
    ov_d    = ov_q;
    case (state_q)
      ST_IDLE: begin
        if (board_valid) begin
          board_d = board;
          mask_d  = '0;
          map_d   = '0;
          kf_d    = 1'b0;
          ksq_d   = '0;
          chk_d   = 1'b0;
          row_d   = '0;
          state_d = ST_COLLECT;
        end
      end
      ST_COLLECT: begin
        // Latest pulse on a square overrides any earlier one
        mask_d = mask_q | attacked_valid;
        map_d  = (map_q & ~attacked_valid) | (attacked & attacked_valid);
        if (&mask_d) begin
          row_d   = '0;
          state_d = ST_SCAN;
        end
      end
      ST_SCAN: begin
        if (!kf_q && row_hit) begin
          kf_d  = 1'b1;
          ksq_d = {row_q, row_col};
          chk_d = map_q[{row_q, row_col}];
        end
        row_d = row_q + 3'd1;
        if (row_q == 3'd7) begin
          cs_d    = span_clear(map_q, BACK_RANK, 3'd4);
          cl_d    = span_clear(map_q, BACK_RANK, 3'd2);
          ov_d    = 1'b1;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        // out_valid is always high here, so ready alone completes the handshake
        if (out_ready) begin
          ov_d    = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State register with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      board_q <= '0;
      mask_q  <= '0;
      row_q   <= '0;
      map_q   <= '0;
      kf_q    <= 1'b0;
      ksq_q   <= '0;
      chk_q   <= 1'b0;
      cs_q    <= 1'b0;
      cl_q    <= 1'b0;
      ov_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      board_q <= board_d;
      mask_q  <= mask_d;
      row_q   <= row_d;
      map_q   <= map_d;
      kf_q    <= kf_d;
      ksq_q   <= ksq_d;
      chk_q   <= chk_d;
      cs_q    <= cs_d;
      cl_q    <= cl_d;
      ov_q    <= ov_d;
    end
  end

  assign busy              = (state_q != ST_IDLE);
  assign out_valid         = ov_q;
  assign attack_map        = map_q;
  assign king_found        = kf_q;
  assign king_sq           = ksq_q;
  assign in_check          = chk_q;
  assign castle_short_safe = cs_q;
  assign castle_long_safe  = cl_q;

endmodule

// File: tb/tb_attack_map_collect.sv
// Bench for attack_map_collect: one white-attacker and one black-attacker
// instance share the same stimulus; results are compared to a square-by-square
// reference model.
module tb_attack_map_collect;
  import attack_map_collect_pkg::*;

  logic         clk = 1'b0;
  logic         reset;
  logic [255:0] board;
  logic         board_valid;
  logic [63:0]  attacked, attacked_valid;
  logic         out_ready;

  logic         busy_w, ov_w, kf_w, chk_w, cs_w, cl_w;
  logic [63:0]  map_w;
  logic [5:0]   ksq_w;
  logic         busy_b, ov_b, kf_b, chk_b, cs_b, cl_b;
  logic [63:0]  map_b;
  logic [5:0]   ksq_b;

  attack_map_collect #(.ATTACKER(WHITE_ATTACK)) dut_w (
    .clk(clk), .reset(reset), .board(board), .board_valid(board_valid),
    .attacked(attacked), .attacked_valid(attacked_valid), .busy(busy_w),
    .out_valid(ov_w), .out_ready(out_ready), .attack_map(map_w),
    .king_found(kf_w), .king_sq(ksq_w), .in_check(chk_w),
    .castle_short_safe(cs_w), .castle_long_safe(cl_w));

  attack_map_collect #(.ATTACKER(BLACK_ATTACK)) dut_b (
    .clk(clk), .reset(reset), .board(board), .board_valid(board_valid),
    .attacked(attacked), .attacked_valid(attacked_valid), .busy(busy_b),
    .out_valid(ov_b), .out_ready(out_ready), .attack_map(map_b),
    .king_found(kf_b), .king_sq(ksq_b), .in_check(chk_b),
    .castle_short_safe(cs_b), .castle_long_safe(cl_b));

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic       kf;
    logic [5:0] ksq;
    logic       chk;
    logic       cs;
    logic       cl;
  } res_t;

  int npass = 0, nchk = 0, nfail = 0;
  logic [63:0]  exp_map;
  logic [255:0] cur_board;
  logic [63:0]  q_av[$], q_a[$];
  int           q_gap[$];
  int unsigned  t_first, t_last, t_out;

  function automatic logic [63:0] r64();
    return {$urandom(), $urandom()};
  endfunction

  function automatic logic [255:0] put(input logic [255:0] b, input int sq, input logic [3:0] code);
    logic [255:0] r;
    r = b;
    r[sq*4 +: 4] = code;
    return r;
  endfunction

  function automatic logic [255:0] rand_board();
    logic [255:0] b;
    int r;
    b = '0;
    for (int s = 0; s < 64; s++) begin
      r = $urandom_range(0, 31);
      b[s*4 +: 4] = (r < 16) ? EMPTY_POSN : 4'(r - 16);
    end
    return b;
  endfunction

  // Reference: first defender king in square order, then attack lookups
  function automatic res_t model(input logic [255:0] b, input logic [63:0] amap, input bit black_att);
    res_t r;
    logic [3:0] kc;
    int rank;
    kc   = black_att ? WHITE_KING : BLACK_KING;
    rank = black_att ? 0 : 7;
    r = '0;
    for (int s = 0; s < 64; s++)
      if (!r.kf && b[s*4 +: 4] == kc) begin
        r.kf  = 1'b1;
        r.ksq = 6'(s);
      end
    r.chk = r.kf ? amap[r.ksq] : 1'b0;
    r.cs  = !amap[rank*8+4] && !amap[rank*8+5] && !amap[rank*8+6];
    r.cl  = !amap[rank*8+2] && !amap[rank*8+3] && !amap[rank*8+4];
    return r;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nchk++;
    assert (obs === exp) npass++;
    else begin
      nfail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic start_board(input logic [255:0] b);
    board       = b;
    board_valid = 1'b1;
    cur_board   = b;
    exp_map     = '0;
    @(negedge clk);
    board_valid = 1'b0;
    board       = {r64(), r64(), r64(), r64()};
    chk("busy_after_start_w", 64'(busy_w), 64'd1);
  endtask

  task automatic deliver();
    for (int i = 0; i < q_av.size(); i++) begin
      attacked_valid = q_av[i];
      attacked       = q_a[i];
      exp_map        = (exp_map & ~q_av[i]) | (q_a[i] & q_av[i]);
      @(negedge clk);
      attacked_valid = '0;
      attacked       = r64();
      if (i == 0) t_first = cyc;
      t_last = cyc;
      repeat (q_gap[i]) @(negedge clk);
    end
    q_av.delete(); q_a.delete(); q_gap.delete();
  endtask

  task automatic check_results(input string pfx);
    res_t rw, rb;
    rw = model(cur_board, exp_map, 1'b0);
    rb = model(cur_board, exp_map, 1'b1);
    chk({pfx, "_map_w"}, map_w, exp_map);
    chk({pfx, "_map_b"}, map_b, exp_map);
    chk({pfx, "_kf_w"},  64'(kf_w),  64'(rw.kf));
    chk({pfx, "_ksq_w"}, 64'(ksq_w), 64'(rw.ksq));
    chk({pfx, "_chk_w"}, 64'(chk_w), 64'(rw.chk));
    chk({pfx, "_cs_w"},  64'(cs_w),  64'(rw.cs));
    chk({pfx, "_cl_w"},  64'(cl_w),  64'(rw.cl));
    chk({pfx, "_kf_b"},  64'(kf_b),  64'(rb.kf));
    chk({pfx, "_ksq_b"}, 64'(ksq_b), 64'(rb.ksq));
    chk({pfx, "_chk_b"}, 64'(chk_b), 64'(rb.chk));
    chk({pfx, "_cs_b"},  64'(cs_b),  64'(rb.cs));
    chk({pfx, "_cl_b"},  64'(cl_b),  64'(rb.cl));
  endtask

  task automatic run_board(input string pfx, input logic [255:0] b);
    int n;
    start_board(b);
    deliver();
    n = 0;
    while (ov_w !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    t_out = cyc;
    chk({pfx, "_out_valid_w"}, 64'(ov_w), 64'd1);
    chk({pfx, "_out_valid_b"}, 64'(ov_b), 64'd1);
    chk({pfx, "_latency"}, 64'(t_out - t_last), 64'd8);
    check_results(pfx);
  endtask

  task automatic handshake(input string pfx);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({pfx, "_hs_busy_w"}, 64'(busy_w), 64'd0);
    chk({pfx, "_hs_busy_b"}, 64'(busy_b), 64'd0);
    chk({pfx, "_hs_ov_w"},   64'(ov_w),   64'd0);
    chk({pfx, "_hs_map_w"},  map_w, exp_map);
  endtask

  // Random partition of all 64 valids into n groups; one reserved square only
  // arrives in the last group so earlier groups cannot complete the mask.
  task automatic make_groups(input int n);
    int keep;
    logic [63:0] uni, av;
    keep = $urandom_range(0, 63);
    uni  = '0;
    for (int g = 0; g < n - 1; g++) begin
      av = r64() & ~(64'd1 << keep);
      uni |= av;
      q_av.push_back(av);
      q_a.push_back(r64());
      q_gap.push_back($urandom_range(0, 2));
    end
    q_av.push_back(~uni | (r64() & r64()));
    q_a.push_back(r64());
    q_gap.push_back(0);
  endtask

  initial begin
    logic [255:0] b;
    res_t rw;
    reset = 1'b1; board = '0; board_valid = 1'b0;
    attacked = '0; attacked_valid = '0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy_w", 64'(busy_w), 64'd0);
    chk("rst_ov_b",   64'(ov_b),   64'd0);
    chk("rst_map_w",  map_w,       64'd0);
    chk("rst_kf_b",   64'(kf_b),   64'd0);
    reset = 1'b0;
    @(negedge clk);

    // Reset in the middle of collection
    start_board(rand_board());
    attacked_valid = 64'h0_FFFFF; attacked = '1;
    @(negedge clk);
    attacked_valid = '0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("midrst_busy_w", 64'(busy_w), 64'd0);
    chk("midrst_busy_b", 64'(busy_b), 64'd0);
    chk("midrst_ov_w",   64'(ov_w),   64'd0);
    chk("midrst_map_w",  map_w,       64'd0);
    make_groups(2);
    run_board("after_rst", rand_board());
    handshake("after_rst");

    // Black king on e8 attacked, white king on e1
    b = put(put('0, 60, BLACK_KING), 4, WHITE_KING);
    q_av.push_back('1); q_a.push_back(64'd1 << 60); q_gap.push_back(0);
    run_board("e8", b);
    handshake("e8");

    // Two halves, three cycles apart
    q_av.push_back(64'h0000_0000_FFFF_FFFF); q_a.push_back(64'h20); q_gap.push_back(2);
    q_av.push_back(64'hFFFF_FFFF_0000_0000); q_a.push_back(64'h0);  q_gap.push_back(0);
    run_board("stagger", rand_board());
    chk("stagger_total", 64'(t_out - t_first), 64'd11);
    chk("stagger_map", map_w, 64'h20);
    handshake("stagger");

    // Empty board, nothing attacked
    q_av.push_back('1); q_a.push_back('0); q_gap.push_back(0);
    run_board("empty", '0);
    handshake("empty");

    // White king e1, d1 attacked
    q_av.push_back('1); q_a.push_back(64'd1 << 3); q_gap.push_back(0);
    run_board("e1", put('0, 4, WHITE_KING));
    handshake("e1");

    // Backpressure with an ignored board_valid, then back-to-back board
    make_groups(3);
    run_board("bp", rand_board());
    rw = model(cur_board, exp_map, 1'b0);
    for (int i = 0; i < 5; i++) begin
      board_valid = (i == 1 || i == 3);
      board       = rand_board();
      attacked_valid = r64(); attacked = r64();
      @(negedge clk);
      chk("bp_hold_ov_w",  64'(ov_w),   64'd1);
      chk("bp_hold_busy",  64'(busy_w), 64'd1);
      chk("bp_hold_map_w", map_w,       exp_map);
      chk("bp_hold_ksq_w", 64'(ksq_w),  64'(rw.ksq));
    end
    board_valid = 1'b0; attacked_valid = '0;
    handshake("bp");
    make_groups(1);
    run_board("bp2", rand_board());
    handshake("bp2");

    // Random boards and random valid schedules
    for (int it = 0; it < 25; it++) begin
      make_groups($urandom_range(1, 4));
      run_board("rnd", rand_board());
      repeat ($urandom_range(0, 3)) @(negedge clk);
      handshake("rnd");
    end

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
